// File: rtl/dma_stream_copier.sv
// Streams cache lines from a DMA read port to a DMA write port, adding a
// 32-bit value to every 32-bit lane through a single-entry output register.
module dma_stream_copier #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [SIZE_WIDTH-1:0] size_in,
    input  logic [31:0]           add_value,
    output logic                  busy,
    output logic                  done,
    output logic                  dma_rd_go,
    output logic                  dma_rd_en,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [SIZE_WIDTH-1:0] dma_rd_size,
    input  logic [DATA_WIDTH-1:0] dma_rd_data,
    input  logic                  dma_empty,
    input  logic                  dma_rd_done,
    output logic                  dma_wr_go,
    output logic                  dma_wr_en,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [SIZE_WIDTH-1:0] dma_wr_size,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_full,
    input  logic                  dma_wr_done,
    output logic [2:0]            dbg_state
);

    localparam int LANES = DATA_WIDTH / 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        COPY      = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [SIZE_WIDTH-1:0] size_q, rd_cnt, wr_cnt, wr_cnt_inc;
    logic [31:0]           add_q;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data_q, lane_sum;
    logic                  accept_go;
    logic                  unused_rd_done;

    // Read completion is implied by the line count; the strobe is not needed.
    assign unused_rd_done = dma_rd_done;

    assign accept_go  = go && (state == IDLE || state == DONE);
    assign wr_cnt_inc = wr_cnt + 1'b1;

    // Lanes wrap independently: no carry crosses a 32-bit boundary.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum[i*32 +: 32] = dma_rd_data[i*32 +: 32] + add_q;
        end
    end

    // Handshake: a pop happens on any cycle dma_rd_en=1 (never while empty),
    // a push on any cycle dma_wr_en=1 (never while full); both are
    // combinational and take effect on the following rising edge.
    always_comb begin
        dma_rd_en = (state == COPY) && !dma_empty && (rd_cnt < size_q)
                    && (!valid || !dma_full);
        dma_wr_en = (state == COPY) && valid && !dma_full;
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        dma_rd_go   = 1'b0;
        dma_wr_go   = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (go) state_nxt = (size_in == '0) ? DONE : START;
            end
            START: begin
                busy      = 1'b1;
                dma_rd_go = 1'b1;
                dma_wr_go = 1'b1;
                state_nxt = COPY;
            end
            COPY: begin
                busy = 1'b1;
                if (dma_wr_en && wr_cnt_inc == size_q) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy = 1'b1;
                if (dma_wr_done) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            size_q    <= '0;
            add_q     <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            valid     <= 1'b0;
            data_q    <= '0;
        end else if (accept_go) begin
            rd_addr_q <= rd_addr_in;
            wr_addr_q <= wr_addr_in;
            size_q    <= size_in;
            add_q     <= add_value;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            valid     <= 1'b0;
        end else begin
            if (dma_rd_en) rd_cnt <= rd_cnt + 1'b1;
            if (dma_wr_en) wr_cnt <= wr_cnt_inc;
            // A pop refills the register even when it drains the same cycle.
            if (dma_rd_en) begin
                valid  <= 1'b1;
                data_q <= lane_sum;
            end else if (dma_wr_en) begin
                valid <= 1'b0;
            end
        end
    end

    assign dma_rd_addr = rd_addr_q;
    assign dma_wr_addr = wr_addr_q;
    assign dma_rd_size = size_q;
    assign dma_wr_size = size_q;
    assign dma_wr_data = data_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_dma_stream_copier.sv
// Directed bench for dma_stream_copier: a queue-backed read source, an
// expected-data queue checked on every write, and per-transfer event counters.
module tb_dma_stream_copier;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic [AW-1:0] rd_addr_in = '0;
  logic [AW-1:0] wr_addr_in = '0;
  logic [SW-1:0] size_in = '0;
  logic [31:0]   add_value = '0;
  logic          busy, done, dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [SW-1:0] dma_rd_size, dma_wr_size;
  logic [DW-1:0] dma_rd_data = '0;
  logic          dma_empty = 1'b1;
  logic          dma_rd_done = 1'b0;
  logic [DW-1:0] dma_wr_data;
  logic          dma_full = 1'b0;
  logic          dma_wr_done = 1'b0;
  logic [2:0]    dbg_state;

  dma_stream_copier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .rd_addr_in(rd_addr_in), .wr_addr_in(wr_addr_in), .size_in(size_in),
    .add_value(add_value), .busy(busy), .done(done),
    .dma_rd_go(dma_rd_go), .dma_rd_en(dma_rd_en),
    .dma_rd_addr(dma_rd_addr), .dma_rd_size(dma_rd_size),
    .dma_rd_data(dma_rd_data), .dma_empty(dma_empty), .dma_rd_done(dma_rd_done),
    .dma_wr_go(dma_wr_go), .dma_wr_en(dma_wr_en),
    .dma_wr_addr(dma_wr_addr), .dma_wr_size(dma_wr_size),
    .dma_wr_data(dma_wr_data), .dma_full(dma_full), .dma_wr_done(dma_wr_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / counters ----------------
  int checks = 0;
  int failures = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic          pop_now = 1'b0;

  int n_rd, n_wr, n_rdgo, n_wrgo, n_busy;
  int first_rd, last_rd, first_wr, last_wr, max_occ;
  int rd_viol, wr_viol;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counters();
    n_rd = 0; n_wr = 0; n_rdgo = 0; n_wrgo = 0; n_busy = 0;
    first_rd = 0; last_rd = 0; first_wr = 0; last_wr = 0; max_occ = 0;
    rd_viol = 0; wr_viol = 0;
  endtask

  // Monitor samples mid-cycle, when DUT outputs are settled.
  always @(negedge clk) begin
    if (n_rd - n_wr > max_occ) max_occ = n_rd - n_wr;
    pop_now = dma_rd_en;
    if (dma_rd_go) n_rdgo++;
    if (dma_wr_go) n_wrgo++;
    if (busy) n_busy++;
    if (dma_rd_en) begin
      if (n_rd == 0) first_rd = cyc;
      last_rd = cyc;
      n_rd++;
      if (dma_empty) rd_viol++;
    end
    if (dma_wr_en) begin
      if (n_wr == 0) first_wr = cyc;
      last_wr = cyc;
      n_wr++;
      if (dma_full) wr_viol++;
      if (exp_q.size() == 0) check("wr_unexpected", 64'(dma_wr_data), 64'hDEAD);
      else check("wr_data", 64'(dma_wr_data), 64'(exp_q.pop_front()));
    end
  end

  // Read source: head of src_q, popped on each accepted dma_rd_en.
  always @(posedge clk) begin
    #1;
    if (pop_now && src_q.size() > 0) void'(src_q.pop_front());
    dma_empty   = (src_q.size() == 0);
    dma_rd_data = (src_q.size() > 0) ? src_q[0] : '0;
  end

  // ---------------- driver ----------------
  // Cycle c=1 is the cycle right after the go edge (START for a non-empty copy).
  task automatic do_transfer(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                             input logic [SW-1:0] sz, input logic [31:0] av,
                             input int full_lo, input int full_hi,
                             input int glitch_c, input int rst_c,
                             output int done_c);
    done_c = -1;
    clear_counters();
    @(posedge clk); #1;
    rd_addr_in = ra; wr_addr_in = wa; size_in = sz; add_value = av; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      dma_full = (c >= full_lo && c <= full_hi);
      if (c == glitch_c) begin
        go = 1'b1; rd_addr_in = ra ^ 32'h0000FFFF; wr_addr_in = wa ^ 32'h00FF0000;
        size_in = sz + 17'd3;
      end else begin
        go = 1'b0;
      end
      if (c == rst_c) begin
        check("state_before_rst", 64'(dbg_state), 64'd2);
        check("rd_cnt_before_rst", 64'(n_rd), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_outputs_zero",
              64'({busy, done, dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en,
                   |dma_rd_addr, |dma_wr_addr, |dma_rd_size, |dma_wr_size,
                   |dma_wr_data, |dbg_state}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dma_full = 1'b0;
        return;
      end
      dma_wr_done = (dbg_state == 3'd3);
      if (dbg_state == 3'd4) begin
        dma_wr_done = 1'b0;
        dma_full = 1'b0;
        done_c = c;
        return;
      end
      @(posedge clk); #1;
    end
    check("transfer_timeout", 64'd1, 64'd0);
  endtask

  // ---------------- tests ----------------
  int dc;

  initial begin
    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", 64'({dbg_state, busy, done, dma_rd_go, dma_wr_go}), 64'd0);

    // Four lines, no add, no back-pressure
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(64'h1111_0000_2222_0000 + 64'(i));
      exp_q.push_back(64'h1111_0000_2222_0000 + 64'(i));
    end
    do_transfer(32'h0000_1000, 32'h0000_8000, 17'd4, 32'd0, 0, -1, 0, 0, dc);
    check("s4_rd_go_pulses", 64'(n_rdgo), 64'd1);
    check("s4_wr_go_pulses", 64'(n_wrgo), 64'd1);
    check("s4_rd_count", 64'(n_rd), 64'd4);
    check("s4_rd_consecutive", 64'(last_rd - first_rd), 64'd3);
    check("s4_wr_count", 64'(n_wr), 64'd4);
    check("s4_wr_lag_first", 64'(first_wr - first_rd), 64'd1);
    check("s4_wr_lag_last", 64'(last_wr - last_rd), 64'd1);
    check("s4_done_cycle", 64'(dc), 64'd8);
    check("s4_done_busy", 64'({done, busy}), 64'b10);
    check("s4_addrs", 64'({dma_rd_addr, dma_wr_addr}), 64'h0000_1000_0000_8000);
    check("s4_sizes", 64'({dma_rd_size, dma_wr_size}), 64'({17'd4, 17'd4}));
    check("s4_exp_drained", 64'(exp_q.size()), 64'd0);

    // Lane wrap: each 32-bit lane wraps on its own
    src_q.push_back(64'h1234_5678_FFFF_FFFF);
    src_q.push_back(64'h7FFF_FFFF_0000_0000);
    exp_q.push_back(64'h1234_5679_0000_0000);
    exp_q.push_back(64'h8000_0000_0000_0001);
    do_transfer(32'h0000_2000, 32'h0000_9000, 17'd2, 32'd1, 0, -1, 0, 0, dc);
    check("lane_wr_count", 64'(n_wr), 64'd2);
    check("lane_exp_drained", 64'(exp_q.size()), 64'd0);

    // Eight lines with the write side full for cycles 3..6
    for (int i = 0; i < 8; i++) begin
      src_q.push_back({32'hA000_0000 + 32'(i), 32'hFFFF_FFF0 + 32'(i)});
      exp_q.push_back({32'hA000_0010 + 32'(i), 32'(i)});
    end
    do_transfer(32'h0000_3000, 32'h0000_A000, 17'd8, 32'h10, 3, 6, 0, 0, dc);
    check("bp_wr_while_full", 64'(wr_viol), 64'd0);
    check("bp_rd_while_empty", 64'(rd_viol), 64'd0);
    check("bp_max_buffered", 64'(max_occ), 64'd1);
    check("bp_first_wr_gap", 64'(first_wr - first_rd), 64'd5);
    check("bp_wr_count", 64'(n_wr), 64'd8);
    check("bp_exp_drained", 64'(exp_q.size()), 64'd0);

    // Zero-length transfer
    do_transfer(32'h0000_4000, 32'h0000_B000, 17'd0, 32'd5, 0, -1, 0, 0, dc);
    check("s0_no_go", 64'(n_rdgo + n_wrgo), 64'd0);
    check("s0_no_busy", 64'(n_busy), 64'd0);
    check("s0_done_cycle", 64'(dc), 64'd1);
    check("s0_done", 64'({done, busy}), 64'b10);

    // go pulsed mid-copy must be ignored
    for (int i = 0; i < 8; i++) begin
      src_q.push_back(64'h0BAD_0000_0000_0100 + 64'(i));
      exp_q.push_back(64'h0BAD_0000_0000_0100 + 64'(i));
    end
    do_transfer(32'h0000_5000, 32'h0000_C000, 17'd8, 32'd0, 0, -1, 4, 0, dc);
    check("glitch_rd_go_pulses", 64'(n_rdgo), 64'd1);
    check("glitch_addrs", 64'({dma_rd_addr, dma_wr_addr}), 64'h0000_5000_0000_C000);
    check("glitch_sizes", 64'({dma_rd_size, dma_wr_size}), 64'({17'd8, 17'd8}));
    check("glitch_wr_count", 64'(n_wr), 64'd8);
    check("glitch_exp_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-copy after three reads, then a clean restart
    for (int i = 0; i < 3; i++) begin
      src_q.push_back(64'h5555_0000_6666_0000 + 64'(i));
      exp_q.push_back(64'h5555_0000_6666_0000 + 64'(i));
    end
    do_transfer(32'h0000_6000, 32'h0000_D000, 17'd8, 32'd0, 0, -1, 0, 7, dc);
    check("rst_exp_drained", 64'(exp_q.size()), 64'd0);
    check("post_rst_state", 64'({dbg_state, dma_rd_addr}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(64'h7777_0000_8888_0000 + 64'(i));
      exp_q.push_back(64'h7777_0001_8888_0001 + 64'(i));
    end
    do_transfer(32'h0000_7000, 32'h0000_E000, 17'd4, 32'd1, 0, -1, 0, 0, dc);
    check("restart_rd_count", 64'(n_rd), 64'd4);
    check("restart_wr_count", 64'(n_wr), 64'd4);
    check("restart_done_cycle", 64'(dc), 64'd8);
    check("restart_exp_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
